instr_exec: RTL and testbench
=============================

INSTR_EXEC -- requirements
Module: instr_exec

Interface
REQ-001 SHALL: one clock; reset is synchronous and active-high; ports named clock and reset.
REQ-002 SHALL: clock  input  1  rising-edge clock for all state.
REQ-003 SHALL: reset  input  1  synchronous active-high reset; dominates every other input.
REQ-004 SHALL: ena  input  1  global enable; when 0, all registers hold.
REQ-005 SHALL: instr_in  input  8  instruction word: [7:5] opcode, [4:0] operand.
REQ-006 SHALL: instr_valid  input  1  instr_in is valid this cycle.
REQ-007 SHALL: instr_ready  output  1  block can accept an instruction (high only in IDLE).
REQ-008 SHALL: pc_ena  output  1  one-cycle pulse that advances the upstream program counter.
REQ-009 SHALL: retire  output  1  one-cycle pulse marking instruction completion (same cycle as pc_ena).
REQ-010 SHALL: acc_out  output  8  registered accumulator value.
REQ-011 SHALL: zero_flag  output  1  registered: last written result == 0.
REQ-012 SHALL: carry_flag  output  1  registered carry/borrow/overflow of the last writing op.
REQ-013 SHALL: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL: FSM states are IDLE, EXEC, MUL, DONE.
REQ-015 SHALL: accept when state==IDLE && instr_valid && ena; latch instr_in into ir; IDLE->EXEC.
REQ-016 SHALL: with instr_valid=0 in IDLE, remain in IDLE with no register change.
REQ-017 SHALL: opcodes: 000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 XOR, 110 LDI (acc=operand), 111 NOP.
REQ-018 SHALL: operand is zero-extended to 8 bits; all results wrap mod 256.
REQ-019 SHALL: ADD carry = bit 8 of acc+operand; SUB carry = borrow (acc < operand); AND/OR/XOR/LDI clear carry.
REQ-020 SHALL: for non-MUL ops, the EXEC edge writes acc and flags and moves EXEC->DONE; NOP writes nothing.
REQ-021 SHALL: for MUL, the EXEC edge clears a 13-bit product and a 3-bit bit counter and moves EXEC->MUL.
REQ-022 SHALL: each MUL edge adds (acc << count) to the product when operand[count]=1 and increments count.
REQ-023 SHALL: the MUL edge with count==4 writes acc=product[7:0], carry=|product[12:8], zero, and moves MUL->DONE.
REQ-024 SHALL: DONE->IDLE on the next enabled edge; retire=pc_ena=(state==DONE)&&ena, combinational.
REQ-025 SHALL: latency from accept edge k: non-MUL result visible after edge k+1, retire in cycle k+1..k+2; MUL result after edge k+6, retire in cycle k+6..k+7.
REQ-026 SHALL: earliest next accept is edge k+3 (non-MUL) or k+8 (MUL).
REQ-027 SHALL: with ena=0 in any state, state, ir, acc, flags and product hold; retire, pc_ena = 0.
REQ-028 SHALL: instr_in and instr_valid are ignored outside IDLE.

Reset
REQ-029 SHALL: on reset at any edge, state=IDLE, acc=0, flags=0, ir=0, product=0, count=0; in-flight op discarded.
REQ-030 SHALL: outputs after reset: instr_ready=1, busy=0, retire=0, pc_ena=0, acc_out=0x00.

Configuration
REQ-031 SHALL: macro INSTR_EXEC_MUL_EN defined -> opcode 010 runs the iterative MUL of REQ-021..023.
REQ-032 SHALL: macro INSTR_EXEC_MUL_EN undefined -> MUL state, product and counter are absent; opcode 010 behaves as NOP (EXEC->DONE, no writes).

Verification
REQ-033 SHALL: reset, then 0x03, 0x22, 0x45 -> acc 0x03, 0x01, 0x05; retire at k+1 twice then k+6; three pc_ena pulses.
REQ-034 SHALL: LDI 0x10 then ADD 0xF0-equivalent via LDI 0x1F, ADD 31 twice... simplified: acc=0xF0 (preload), ADD 31 (0x1F) -> acc 0x0F, carry=1, zero=0.
REQ-035 SHALL: acc=0x01, SUB 2 (0x22) -> acc 0xFF, carry=1; then SUB 31 on acc=0x1F -> acc 0x00, zero=1, carry=0.
REQ-036 SHALL: acc=0x10, MUL 31 (0x5F) -> acc 0xF0, carry=1; with macro undefined -> acc stays 0x10, retire at k+1.
REQ-037 SHALL: reset asserted during MUL with count==2 -> next cycle state IDLE, acc 0x00, instr_ready=1, no retire pulse.
REQ-038 SHALL: ena=0 for 3 cycles while in EXEC with ADD 3 -> acc unchanged during stall; retire delayed exactly 3 cycles.

Source files
------------

// File: rtl/instr_exec.sv
// Multi-cycle accumulator executor: IDLE -> EXEC (-> MUL) -> DONE, one instruction at a time.
// Defining INSTR_EXEC_MUL_EN enables the iterative shift-add MUL; otherwise opcode 010 is a NOP.
module instr_exec (
  input  logic       clock,
  input  logic       reset,
  input  logic       ena,
  input  logic [7:0] instr_in,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic       pc_ena,
  output logic       retire,
  output logic [7:0] acc_out,
  output logic       zero_flag,
  output logic       carry_flag,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
`ifdef INSTR_EXEC_MUL_EN
    S_MUL  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_LDI = 3'b110,
    OP_NOP = 3'b111
  } opcode_t;

  state_t     state;
  logic [7:0] ir;
  logic [7:0] acc;
  logic       zero;
  logic       carry;

  opcode_t    opcode;
  logic [7:0] operand;
  logic [7:0] alu_res;
  logic       alu_carry;
  logic       alu_write;

  assign opcode  = opcode_t'(ir[7:5]);
  assign operand = {3'b000, ir[4:0]};

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    alu_res   = acc;
    alu_carry = 1'b0;
    alu_write = 1'b0;
    case (opcode)
      OP_ADD: begin {alu_carry, alu_res} = {1'b0, acc} + {1'b0, operand}; alu_write = 1'b1; end
      OP_SUB: begin alu_res = acc - operand; alu_carry = (acc < operand); alu_write = 1'b1; end
      OP_AND: begin alu_res = acc & operand; alu_write = 1'b1; end
      OP_OR:  begin alu_res = acc | operand; alu_write = 1'b1; end
      OP_XOR: begin alu_res = acc ^ operand; alu_write = 1'b1; end
      OP_LDI: begin alu_res = operand;       alu_write = 1'b1; end
      default: ;
    endcase
  end

`ifdef INSTR_EXEC_MUL_EN
  logic [12:0] product;
  logic [2:0]  count;
  logic [12:0] mul_sum;

  // The final (count==4) step folds its own partial product into the written result.
  assign mul_sum = product + (ir[count] ? (13'(acc) << count) : 13'd0);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      ir    <= 8'h00;
      acc   <= 8'h00;
      zero  <= 1'b0;
      carry <= 1'b0;
`ifdef INSTR_EXEC_MUL_EN
      product <= 13'd0;
      count   <= 3'd0;
`endif
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir    <= instr_in;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_DONE;
          if (alu_write) begin
            acc   <= alu_res;
            zero  <= (alu_res == 8'h00);
            carry <= alu_carry;
          end
`ifdef INSTR_EXEC_MUL_EN
          if (opcode == OP_MUL) begin
            product <= 13'd0;
            count   <= 3'd0;
            state   <= S_MUL;
          end
        end
        S_MUL: begin
          product <= mul_sum;
          count   <= count + 3'd1;
          if (count == 3'd4) begin
            acc   <= mul_sum[7:0];
            zero  <= (mul_sum[7:0] == 8'h00);
            carry <= |mul_sum[12:8];
            state <= S_DONE;
          end
`endif
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign retire      = (state == S_DONE) && ena;
  assign pc_ena      = retire;
  assign acc_out     = acc;
  assign zero_flag   = zero;
  assign carry_flag  = carry;

endmodule

// File: tb/tb_instr_exec.sv
// Directed self-checking bench for instr_exec; expected MUL results follow INSTR_EXEC_MUL_EN.
module tb_instr_exec;

  logic       clock = 1'b0;
  logic       reset;
  logic       ena;
  logic [7:0] instr_in;
  logic       instr_valid;
  logic       instr_ready;
  logic       pc_ena;
  logic       retire;
  logic [7:0] acc_out;
  logic       zero_flag;
  logic       carry_flag;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int pc_pulses = 0;

  instr_exec dut (
    .clock       (clock),
    .reset       (reset),
    .ena         (ena),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_ena      (pc_ena),
    .retire      (retire),
    .acc_out     (acc_out),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (pc_ena) pc_pulses++;

`ifdef INSTR_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one instruction, wait for retire, then check latency, result and return to IDLE.
  task automatic run(input string tag, input logic [7:0] instr, input int exp_lat,
                     input logic [7:0] exp_acc, input logic exp_z, input logic exp_c);
    int n;
    check({tag, " ready"}, instr_ready, 1);
    instr_in    = instr;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr_in    = 8'hFF;
    n = 0;
    while (!retire && n < 20) begin
      step();
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " pc_ena"}, pc_ena, 1);
    check({tag, " acc"}, acc_out, exp_acc);
    check({tag, " zero"}, zero_flag, exp_z);
    check({tag, " carry"}, carry_flag, exp_c);
    step();
    check({tag, " idle"}, {retire, busy, instr_ready}, 3'b001);
  endtask

  initial begin
    int base;
    int lat;
    int n;
    logic [7:0] mul_acc;

    reset = 1'b1; ena = 1'b1; instr_valid = 1'b0; instr_in = 8'h00;
    step();
    step();
    check("reset outs", {instr_ready, busy, retire, pc_ena}, 4'b1000);
    check("reset acc", acc_out, 8'h00);
    check("reset flags", {zero_flag, carry_flag}, 2'b00);
    reset = 1'b0;
    step();
    check("idle hold", {busy, acc_out}, 9'h000);

    // Basic ADD / SUB / MUL sequence with pulse counting.
    base = pc_pulses;
    lat = MUL_EN ? 6 : 1;
    mul_acc = MUL_EN ? 8'h05 : 8'h01;
    run("add3", 8'h03, 1, 8'h03, 1'b0, 1'b0);
    run("sub2", 8'h22, 1, 8'h01, 1'b0, 1'b0);
    run("mul5", 8'h45, lat, mul_acc, 1'b0, 1'b0);
    check("pc pulses", pc_pulses - base, 3);

    // ADD carry out of bit 7 with 0xF0 built from LDI/SUB.
    run("ldi0f", 8'hCF, 1, 8'h0F, 1'b0, 1'b0);
    run("sub31", 8'h3F, 1, 8'hF0, 1'b0, 1'b1);
    run("add31", 8'h1F, 1, 8'h0F, 1'b0, 1'b1);

    // SUB borrow, logic ops clear carry, zero result.
    run("ldi1", 8'hC1, 1, 8'h01, 1'b0, 1'b0);
    run("sub2b", 8'h22, 1, 8'hFF, 1'b0, 1'b1);
    run("and1f", 8'h7F, 1, 8'h1F, 1'b0, 1'b0);
    run("sub31z", 8'h3F, 1, 8'h00, 1'b1, 1'b0);
    run("ldi1a", 8'hDA, 1, 8'h1A, 1'b0, 1'b0);
    run("and0f", 8'h6F, 1, 8'h0A, 1'b0, 1'b0);
    run("or11", 8'h91, 1, 8'h1B, 1'b0, 1'b0);
    run("xor1b", 8'hBB, 1, 8'h00, 1'b1, 1'b0);
    run("nop", 8'hE0, 1, 8'h00, 1'b1, 1'b0);

    // MUL with overflow into product[12:8], then MUL by zero.
    run("ldi10", 8'hD0, 1, 8'h10, 1'b0, 1'b0);
    run("mul31", 8'h5F, lat, MUL_EN ? 8'hF0 : 8'h10, 1'b0, MUL_EN);
    run("mul0", 8'h40, lat, MUL_EN ? 8'h00 : 8'h10, MUL_EN, 1'b0);

    // ena=0 in IDLE blocks accept.
    run("ldi5", 8'hC5, 1, 8'h05, 1'b0, 1'b0);
    ena = 1'b0; instr_in = 8'hC0; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0; ena = 1'b1;
    check("ena0 idle", {busy, acc_out}, 9'h005);

    // Stall three cycles in EXEC with ADD 3; retire slips by exactly 3.
    instr_in = 8'h03; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0; ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall hold", {retire, busy, acc_out}, {2'b01, 8'h05});
    end
    ena = 1'b1;
    n = 3;
    while (!retire && n < 20) begin
      step();
      n++;
    end
    check("stall latency", n, 4);
    check("stall acc", acc_out, 8'h08);
    // ena=0 in DONE suppresses the pulse and holds the state.
    ena = 1'b0;
    #1;
    check("done ena0", {retire, pc_ena}, 2'b00);
    step();
    check("done hold", busy, 1);
    ena = 1'b1;
    #1;
    check("done resume", retire, 1);
    step();
    check("after stall", {busy, instr_ready}, 2'b01);

    // Reset in flight (MUL count==2 when the multiplier is present).
    run("ldi10r", 8'hD0, 1, 8'h10, 1'b0, 1'b0);
    instr_in = 8'h5F; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst outs", {instr_ready, busy, retire}, 3'b100);
    check("midrst acc", {acc_out, zero_flag, carry_flag}, 10'h000);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (retire) n++;
    end
    check("midrst no retire", n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
